// File: rtl/fcims_txn_engine.sv
// fcims_txn_engine: item stock/price transaction engine with a running bill.
// Requests come in over a valid/ready handshake. A sell uses a shift-add multiplier.
// Every state update is committed on the CALC->RESP edge.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_op/req_item/req_qty  : request handshake
//   rsp_valid/rsp_ready/rsp_status               : response handshake
//   fprice, new_ct                               : per-request results
//   bill_total, bill_ovf                         : running saturating bill + sticky overflow
module fcims_txn_engine #(
    parameter int unsigned N_ITEMS = 4,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned PRICE_W = 4,
    parameter int unsigned QTY_W   = 4,
    parameter int unsigned BILL_W  = 16,
    localparam int unsigned IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1,
    localparam int unsigned FP_W   = PRICE_W + QTY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [IDX_W-1:0]   req_item,
    input  logic [QTY_W-1:0]   req_qty,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_status,
    output logic [FP_W-1:0]    fprice,
    output logic [CNT_W-1:0]   new_ct,
    output logic [BILL_W-1:0]  bill_total,
    output logic               bill_ovf
);

    localparam int unsigned STEP_W = (QTY_W > 1) ? $clog2(QTY_W) : 1;
    localparam int unsigned RS_W   = ((CNT_W > QTY_W) ? CNT_W : QTY_W) + 1;
    localparam int unsigned SUM_W  = ((BILL_W > FP_W) ? BILL_W : FP_W) + 1;

    localparam logic [1:0] OP_RESTOCK   = 2'b00;
    localparam logic [1:0] OP_SELL      = 2'b01;
    localparam logic [1:0] OP_SETPRICE  = 2'b10;
    localparam logic [1:0] OP_CLEARBILL = 2'b11;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_SHORT  = 2'b01;
    localparam logic [1:0] ST_SAT    = 2'b10;
    localparam logic [1:0] ST_BADIDX = 2'b11;

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e             state;
    logic [1:0]         op;
    logic [IDX_W-1:0]   item;
    logic [QTY_W-1:0]   qty;
    logic [FP_W-1:0]    acc;
    logic [STEP_W-1:0]  step;
    logic [CNT_W-1:0]   counts [N_ITEMS];
    logic [PRICE_W-1:0] prices [N_ITEMS];

    logic               item_ok;
    logic [CNT_W-1:0]   cur_ct;
    logic [PRICE_W-1:0] cur_price;
    logic [RS_W-1:0]    rs_sum;
    logic               rs_clip;
    logic               short_qty;
    logic [RS_W-1:0]    sell_rem;
    logic               sell_go;
    logic               last_step;
    logic [FP_W-1:0]    prod;
    logic [SUM_W-1:0]   bill_sum;
    logic               bill_sat;

    assign req_ready = (state == StIdle);
    assign rsp_valid = (state == StResp);

    always_comb begin
        item_ok   = 32'(item) < N_ITEMS;
        cur_ct    = '0;
        cur_price = '0;
        if (item_ok) begin
            cur_ct    = counts[item];
            cur_price = prices[item];
        end
        rs_sum    = RS_W'(cur_ct) + RS_W'(qty);
        rs_clip   = |rs_sum[RS_W-1:CNT_W];
        short_qty = RS_W'(qty) > RS_W'(cur_ct);
        sell_rem  = RS_W'(cur_ct) - RS_W'(qty);
        sell_go   = (op == OP_SELL) && item_ok && !short_qty;
        last_step = (step == STEP_W'(QTY_W - 1));
        // One shift-add step per CALC cycle: add price << step when qty bit [step] is set.
        prod      = acc + (qty[step] ? (FP_W'(cur_price) << step) : '0);
        bill_sum  = SUM_W'(bill_total) + SUM_W'(prod);
        bill_sat  = bill_sum > SUM_W'({BILL_W{1'b1}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            op         <= '0;
            item       <= '0;
            qty        <= '0;
            acc        <= '0;
            step       <= '0;
            rsp_status <= '0;
            fprice     <= '0;
            new_ct     <= '0;
            bill_total <= '0;
            bill_ovf   <= 1'b0;
            for (int i = 0; i < int'(N_ITEMS); i++) begin
                counts[i] <= '0;
                prices[i] <= '0;
            end
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        op    <= req_op;
                        item  <= req_item;
                        qty   <= req_qty;
                        acc   <= '0;
                        step  <= '0;
                        state <= StCalc;
                    end
                end
                StCalc: begin
                    if (sell_go && !last_step) begin
                        acc  <= prod;
                        step <= step + 1'b1;
                    end else begin
                        state      <= StResp;
                        rsp_status <= ST_OK;
                        fprice     <= '0;
                        new_ct     <= '0;
                        unique case (op)
                            OP_RESTOCK: begin
                                if (!item_ok) begin
                                    rsp_status <= ST_BADIDX;
                                end else begin
                                    counts[item] <= rs_clip ? {CNT_W{1'b1}} : rs_sum[CNT_W-1:0];
                                    new_ct       <= rs_clip ? {CNT_W{1'b1}} : rs_sum[CNT_W-1:0];
                                    rsp_status   <= rs_clip ? ST_SAT : ST_OK;
                                end
                            end
                            OP_SELL: begin
                                if (!item_ok) begin
                                    rsp_status <= ST_BADIDX;
                                end else if (short_qty) begin
                                    rsp_status <= ST_SHORT;
                                    new_ct     <= cur_ct;
                                end else begin
                                    counts[item] <= sell_rem[CNT_W-1:0];
                                    new_ct       <= sell_rem[CNT_W-1:0];
                                    fprice       <= prod;
                                    bill_total   <= bill_sat ? {BILL_W{1'b1}} : bill_sum[BILL_W-1:0];
                                    if (bill_sat) begin
                                        bill_ovf <= 1'b1;
                                    end
                                end
                            end
                            OP_SETPRICE: begin
                                if (!item_ok) begin
                                    rsp_status <= ST_BADIDX;
                                end else begin
                                    prices[item] <= qty[PRICE_W-1:0];
                                    new_ct       <= cur_ct;
                                end
                            end
                            OP_CLEARBILL: begin
                                bill_total <= '0;
                                bill_ovf   <= 1'b0;
                            end
                        endcase
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fcims_txn_engine.sv
// Directed bench for fcims_txn_engine. The DUT uses N_ITEMS=5, which makes
// index 5 representable and out of range. It uses BILL_W=8 so that bill
// saturation can be reached. The other parameters keep their defaults.
module tb_fcims_txn_engine;

    localparam int unsigned N_ITEMS = 5;
    localparam int unsigned QTY_W   = 4;

    localparam logic [1:0] RESTOCK = 2'b00, SELL = 2'b01, SETPRICE = 2'b10, CLEARBILL = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = '0;
    logic [2:0] req_item = '0;
    logic [3:0] req_qty = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_status;
    logic [7:0] fprice;
    logic [3:0] new_ct;
    logic [7:0] bill_total;
    logic       bill_ovf;

    int n_cmp = 0;
    int n_err = 0;

    fcims_txn_engine #(
        .N_ITEMS (N_ITEMS),
        .CNT_W   (4),
        .PRICE_W (4),
        .QTY_W   (QTY_W),
        .BILL_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_item   (req_item),
        .req_qty    (req_qty),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .fprice     (fprice),
        .new_ct     (new_ct),
        .bill_total (bill_total),
        .bill_ovf   (bill_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request, check it is accepted, then count edges until the response.
    task automatic send(input logic [1:0] o, input logic [2:0] it, input logic [3:0] q,
                        input int exp_lat, input string tag);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = o;
        req_item  = it;
        req_qty   = q;
        chk({tag, "_req_ready"}, 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic release_rsp(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 1);
    endtask

    task automatic chk_rsp(input string tag, input int st, input int ct, input int fp,
                           input int bill, input int ovf);
        chk({tag, "_status"}, 32'(rsp_status), st);
        chk({tag, "_new_ct"}, 32'(new_ct), ct);
        chk({tag, "_fprice"}, 32'(fprice), fp);
        chk({tag, "_bill"}, 32'(bill_total), bill);
        chk({tag, "_ovf"}, 32'(bill_ovf), ovf);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk_rsp("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: restock item0 by 3
        send(RESTOCK, 3'd0, 4'd3, 1, "t1_restock");
        chk_rsp("t1", 0, 3, 0, 0, 0);
        release_rsp("t1");

        // 2: price 9, sell 3 -> 27
        send(SETPRICE, 3'd0, 4'd9, 1, "t2_setprice");
        chk_rsp("t2_setprice", 0, 3, 0, 0, 0);
        release_rsp("t2a");
        send(SELL, 3'd0, 4'd3, QTY_W, "t2_sell");
        chk_rsp("t2_sell", 0, 0, 27, 27, 0);
        release_rsp("t2b");

        // 3: short sell leaves everything alone
        send(RESTOCK, 3'd1, 4'd3, 1, "t3_restock");
        chk_rsp("t3_restock", 0, 3, 0, 27, 0);
        release_rsp("t3a");
        send(SELL, 3'd1, 4'd5, 1, "t3_sell");
        chk_rsp("t3_short", 1, 3, 0, 27, 0);
        release_rsp("t3b");

        // Zero-quantity sell on an empty item is still OK
        send(SELL, 3'd0, 4'd0, QTY_W, "q0_sell");
        chk_rsp("q0_sell", 0, 0, 0, 27, 0);
        release_rsp("q0");

        // 4: restock saturation, out-of-range index
        send(RESTOCK, 3'd2, 4'd10, 1, "t4_rs1");
        chk_rsp("t4_rs1", 0, 10, 0, 27, 0);
        release_rsp("t4a");
        send(RESTOCK, 3'd2, 4'd10, 1, "t4_rs2");
        chk_rsp("t4_sat", 2, 15, 0, 27, 0);
        release_rsp("t4b");
        send(RESTOCK, 3'd5, 4'd1, 1, "t4_badrs");
        chk_rsp("t4_badrs", 3, 0, 0, 27, 0);
        release_rsp("t4c");
        send(SELL, 3'd5, 4'd1, 1, "t4_badsell");
        chk_rsp("t4_badsell", 3, 0, 0, 27, 0);
        release_rsp("t4d");

        // 5: hold the response while a new request is presented
        send(RESTOCK, 3'd1, 4'd2, 1, "t5_restock");
        chk_rsp("t5", 0, 5, 0, 27, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = RESTOCK;
            req_item  = 3'd1;
            req_qty   = 4'd7;
            @(posedge clk);
            #1;
            chk("t5_hold_valid", 32'(rsp_valid), 1);
            chk("t5_hold_ready", 32'(req_ready), 0);
            chk("t5_hold_ct", 32'(new_ct), 5);
            chk("t5_hold_status", 32'(rsp_status), 0);
        end
        req_valid = 1'b0;
        release_rsp("t5");
        send(SETPRICE, 3'd1, 4'd0, 1, "t5_probe");
        chk("t5_ignored_req", 32'(new_ct), 5);
        release_rsp("t5p");

        // 6: bill saturation with BILL_W=8
        send(CLEARBILL, 3'd0, 4'd0, 1, "t6_clr0");
        chk_rsp("t6_clr0", 0, 0, 0, 0, 0);
        release_rsp("t6a");
        send(SETPRICE, 3'd3, 4'd15, 1, "t6_price");
        release_rsp("t6b");
        send(RESTOCK, 3'd3, 4'd15, 1, "t6_rs1");
        chk_rsp("t6_rs1", 0, 15, 0, 0, 0);
        release_rsp("t6c");
        send(SELL, 3'd3, 4'd15, QTY_W, "t6_sell1");
        chk_rsp("t6_sell1", 0, 0, 225, 225, 0);
        release_rsp("t6d");
        send(RESTOCK, 3'd3, 4'd15, 1, "t6_rs2");
        release_rsp("t6e");
        send(SELL, 3'd3, 4'd15, QTY_W, "t6_sell2");
        chk_rsp("t6_sell2", 0, 0, 225, 255, 1);
        release_rsp("t6f");
        send(CLEARBILL, 3'd4, 4'd9, 1, "t6_clr1");
        chk_rsp("t6_clr1", 0, 0, 0, 0, 0);
        release_rsp("t6g");

        // Reset in the middle of a sell aborts it
        send(RESTOCK, 3'd3, 4'd15, 1, "t6_rs3");
        release_rsp("t6h");
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = SELL;
        req_item  = 3'd3;
        req_qty   = 4'd15;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_mid_calc", 32'(rsp_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_abort_valid", 32'(rsp_valid), 0);
        chk("t6_abort_ready", 32'(req_ready), 1);
        chk("t6_abort_bill", 32'(bill_total), 0);
        @(negedge clk);
        reset = 1'b1;
        send(SETPRICE, 3'd3, 4'd1, 1, "t6_post");
        chk_rsp("t6_post", 0, 0, 0, 0, 0);
        release_rsp("t6i");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
